// File: rtl/maze_pkg.sv
// Shared types and constants for the depth-first maze solver.
package maze_pkg;

    localparam int MAZE_DIM_LOG2 = 4;

    localparam logic [1:0] CELL_FREE    = 2'b00;
    localparam logic [1:0] CELL_WALL    = 2'b01;
    localparam logic [1:0] CELL_VISITED = 2'b10;
    localparam logic [1:0] CELL_PATH    = 2'b11;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    // Up<->down and right<->left differ only in the upper bit.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_START,
        S_EV_START,
        S_MARK,
        S_PROBE,
        S_EVAL,
        S_BACK,
        S_PATH,
        S_DONE,
        S_FAIL
    } state_t;

endpackage

// File: rtl/maze_solver_dir_stack.sv
// LIFO of move directions taken by the rat; top-of-stack is the last move.
module dir_stack #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [1:0] din_i,
    output logic       empty_o,
    output logic [1:0] top_o
);
    localparam logic [DEPTH_LOG2:0]   SP_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = DEPTH_LOG2'(1);

    logic [1:0]          mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] sp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sp_q <= '0;
        else if (clr_i)  sp_q <= '0;
        else if (push_i) sp_q <= sp_q + SP_ONE;
        else if (pop_i)  sp_q <= sp_q - SP_ONE;
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[sp_q[DEPTH_LOG2-1:0]] <= din_i;
    end

    assign empty_o = (sp_q == '0);
    assign top_o   = mem_q[sp_q[DEPTH_LOG2-1:0] - IDX_ONE];

    a_no_push_pop: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && pop_i));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && sp_q[DEPTH_LOG2]));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));

endmodule

// File: rtl/maze_solver.sv
// Depth-first rat-in-maze solver driving a 2-bit-per-cell maze memory.
// state     | meaning
// IDLE      | waiting for start; done/found hold last result
// RD_START  | read cell (0,0)
// EV_START  | (0,0) wall -> FAIL, else MARK
// MARK      | write visited to rat cell; goal -> PATH
// PROBE     | read neighbour in dir, or skip it if out of bounds
// EVAL      | free neighbour -> move and push, else next dir
// BACK      | pop a move and step back, or FAIL when stack empty
// PATH      | write path to rat cell and unwind one move per cycle
// DONE/FAIL | raise done with found=1/0, return to IDLE
module maze_solver
    import maze_pkg::*;
#(
    parameter int DIM_LOG2 = MAZE_DIM_LOG2,
    parameter int ADR_W    = 16,
    parameter int N        = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADR_W-1:0]    mem_adr,
    output logic                mem_read,
    output logic                mem_write,
    output logic [N-1:0]        mem_din,
    input  logic [N-1:0]        mem_dout,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [DIM_LOG2-1:0] rat_row,
    output logic [DIM_LOG2-1:0] rat_col,
    output logic [8:0]          path_len
);
    localparam logic [DIM_LOG2-1:0] ONE = DIM_LOG2'(1);

    state_t              state_q, state_d;
    logic [DIM_LOG2-1:0] row_q, row_d, col_q, col_d;
    dir_t                dir_q, dir_d;
    logic [8:0]          len_q, len_d, unwind_q, unwind_d;
    logic                found_q, found_d, done_q, done_d;

    logic                stk_clr, stk_push, stk_pop, stk_empty;
    logic [1:0]          stk_top;
    logic [DIM_LOG2-1:0] nb_row, nb_col, bk_row, bk_col, adr_row, adr_col;
    logic                nb_oob, at_goal;

    function automatic logic [2*DIM_LOG2-1:0] step(input logic [DIM_LOG2-1:0] r,
                                                   input logic [DIM_LOG2-1:0] c,
                                                   input dir_t d);
        case (d)
            DIR_UP:    return {r - ONE, c};
            DIR_RIGHT: return {r, c + ONE};
            DIR_DOWN:  return {r + ONE, c};
            default:   return {r, c - ONE};
        endcase
    endfunction

    dir_stack #(.DEPTH_LOG2(2*DIM_LOG2)) u_stack (
        .clk     (clk),
        .rst_n   (rst),
        .clr_i   (stk_clr),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .din_i   (dir_q),
        .empty_o (stk_empty),
        .top_o   (stk_top)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            dir_q    <= DIR_UP;
            len_q    <= '0;
            unwind_q <= '0;
            found_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            dir_q    <= dir_d;
            len_q    <= len_d;
            unwind_q <= unwind_d;
            found_q  <= found_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        nb_oob = 1'b0;
        case (dir_q)
            DIR_UP:    nb_oob = (row_q == '0);
            DIR_RIGHT: nb_oob = (col_q == '1);
            DIR_DOWN:  nb_oob = (row_q == '1);
            default:   nb_oob = (col_q == '0);
        endcase
        {nb_row, nb_col} = step(row_q, col_q, dir_q);
        {bk_row, bk_col} = step(row_q, col_q, opposite(dir_t'(stk_top)));
        at_goal = (row_q == '1) && (col_q == '1);
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        dir_d     = dir_q;
        len_d     = len_q;
        unwind_d  = unwind_q;
        found_d   = found_q;
        done_d    = done_q;
        stk_clr   = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_din   = '0;
        adr_row   = row_q;
        adr_col   = col_q;
        case (state_q)
            S_IDLE: if (start) begin
                row_d   = '0;
                col_d   = '0;
                len_d   = '0;
                found_d = 1'b0;
                done_d  = 1'b0;
                stk_clr = 1'b1;
                state_d = S_RD_START;
            end
            S_RD_START: begin
                mem_read = 1'b1;
                state_d  = S_EV_START;
            end
            S_EV_START: state_d = (mem_dout == N'(CELL_WALL)) ? S_FAIL : S_MARK;
            S_MARK: begin
                mem_write = 1'b1;
                mem_din   = N'(CELL_VISITED);
                if (at_goal) begin
                    unwind_d = len_q;
                    state_d  = S_PATH;
                end else begin
                    dir_d   = DIR_UP;
                    state_d = S_PROBE;
                end
            end
            S_PROBE: begin
                if (nb_oob) begin
                    if (dir_q == DIR_LEFT) state_d = S_BACK;
                    else                   dir_d   = dir_t'(dir_q + 2'd1);
                end else begin
                    mem_read = 1'b1;
                    adr_row  = nb_row;
                    adr_col  = nb_col;
                    state_d  = S_EVAL;
                end
            end
            S_EVAL: begin
                if (mem_dout == N'(CELL_FREE)) begin
                    row_d    = nb_row;
                    col_d    = nb_col;
                    stk_push = 1'b1;
                    len_d    = len_q + 9'd1;
                    state_d  = S_MARK;
                end else if (dir_q == DIR_LEFT) begin
                    state_d = S_BACK;
                end else begin
                    dir_d   = dir_t'(dir_q + 2'd1);
                    state_d = S_PROBE;
                end
            end
            S_BACK: begin
                if (stk_empty) begin
                    state_d = S_FAIL;
                end else begin
                    stk_pop = 1'b1;
                    row_d   = bk_row;
                    col_d   = bk_col;
                    len_d   = len_q - 9'd1;
                    // A popped left move has no directions left to try here.
                    if (stk_top == 2'(DIR_LEFT)) begin
                        state_d = S_BACK;
                    end else begin
                        dir_d   = dir_t'(stk_top + 2'd1);
                        state_d = S_PROBE;
                    end
                end
            end
            S_PATH: begin
                mem_write = 1'b1;
                mem_din   = N'(CELL_PATH);
                if (unwind_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    stk_pop  = 1'b1;
                    row_d    = bk_row;
                    col_d    = bk_col;
                    unwind_d = unwind_q - 9'd1;
                end
            end
            S_DONE: begin
                found_d = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                found_d = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_adr  = {{(ADR_W-2*DIM_LOG2){1'b0}}, adr_row, adr_col};
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign found    = found_q;
    assign rat_row  = row_q;
    assign rat_col  = col_q;
    assign path_len = len_q;

endmodule

// File: doc/maze_solver.md
# maze_solver

Depth-first maze solver for the rat-in-maze datapath. Sits directly upstream of the 2-bit-per-cell maze memory: drives its address, read, write and data-in ports, consumes its registered read data, and marks cells visited, then marks the solution path. Downstream display logic reads the marked maze through the memory's second port once `done` rises.

## Interface

Parameters:
- `DIM_LOG2`, 4: log2 of maze side; maze is 2^DIM_LOG2 × 2^DIM_LOG2 cells (16×16 = 256).
- `ADR_W`, 16: memory address width.
- `N`, 2: cell width, matching the memory data width.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a solve; ignored while `busy`.
- `mem_adr` out ADR_W: cell address {zero-pad, row, col}, so row is in the upper DIM_LOG2 bits and col in the lower.
- `mem_read` out 1: memory read strobe; data is valid on `mem_dout` the next cycle.
- `mem_write` out 1: memory write strobe.
- `mem_din` out N: cell code to write.
- `mem_dout` in N: memory registered read data.
- `busy` out 1: solve in progress.
- `done` out 1: high from the end of a solve until the next accepted `start`.
- `found` out 1: valid when `done`; 1 means a path exists.
- `rat_row`, `rat_col` out DIM_LOG2 each: current rat cell.
- `path_len` out 9: number of moves from (0,0) to the goal on the found path.

## Operation

Cell codes:
- 2'b00: free.
- 2'b01: wall.
- 2'b10: visited.
- 2'b11: path.

Solve rules:
- Start cell is (0,0). Goal cell is (max,max).
- Directions are probed in fixed order: 0 up, 1 right, 2 down, 3 left.

States:
- `IDLE`: on `start`, load rat at (0,0), clear the stack, `path_len`, `found` and `done`, then go to `RD_START`.
- `RD_START` (read (0,0)) → `EV_START`: wall → `FAIL`; otherwise → `MARK`.
- `MARK`: write 2'b10 to the rat cell.
  - If the rat cell is the goal → `PATH`.
  - Otherwise set the probe direction to 0 → `PROBE`.
- `PROBE`:
  - Neighbour out of bounds: advance the direction, no memory access, 1 cycle.
  - Otherwise issue `mem_read` for the neighbour → `EVAL`.
  - After direction 3 is exhausted → `BACK`.
- `EVAL`:
  - `mem_dout` == 00: move the rat to the neighbour, push the direction, `path_len`+1, → `MARK`.
  - Any other code: advance the direction → `PROBE`.
- `BACK`:
  - Stack empty → `FAIL`.
  - Otherwise pop direction d, step the rat opposite to d, `path_len`−1, resume `PROBE` at direction d+1.
- `PATH`: write 2'b11 to the rat cell, then:
  - Stack empty → `DONE`.
  - Otherwise pop and step back one cell per write.
- `DONE`: `found`=1, `done`=1 → `IDLE`.
- `FAIL`: `found`=0, `done`=1 → `IDLE`.

Rules:
- `mem_read` and `mem_write` are never high in the same cycle. Both are 0 outside `PROBE`, `RD_START`, `MARK` and `PATH`.
- `path_len` is frozen during `PATH`. A shadow counter drives the unwinding.
- The stack depth is 256 × 2 bits. Overflow cannot occur, because a path has at most 255 moves; an assertion checks this.

## Timing

- Reset values: every output 0, `mem_adr`=0, state `IDLE`, stack pointer 0.
- Reset mid-solve aborts immediately. No further memory writes; partially marked cells remain in memory.
- Start latency: `start` at edge k → `mem_read` for (0,0) at edge k+1.
- Probe latency:
  - In-bounds probe: 2 cycles (`PROBE`, `EVAL`).
  - Out-of-bounds probe: 1 cycle.
  - Move: probe cycles + 1 (`MARK`).
  - Backtrack: 1 cycle per pop.
- Path marking: exactly `path_len`+1 write cycles.
- `done` rises the cycle after `DONE`/`FAIL` is entered and stays high until the next accepted `start`. `busy` falls on the same edge.
- `start` while `busy`: ignored, no effect.
- `start` on the same edge `done` rises: accepted.

## Structure

- Package `maze_pkg`:
  - cell code constants,
  - direction encoding and its opposite function,
  - state enum,
  - `DIM_LOG2` default.
- Sub-module `dir_stack`: synchronous LIFO, 256 × 2 bits, with push/pop, empty flag and top-of-stack output. Push and pop in the same cycle is illegal.
- Neighbour/bounds computation stays combinational inside `maze_solver`.

## Test plan

- All-free maze, `start` → rat goes right along row 0 to (0,15), then down to (15,15). `found`=1, `path_len`=30, 31 cells hold 2'b11, the rest hold 2'b10 or 00.
- Cell (0,0) = wall → `done`=1, `found`=0 within 3 cycles of `start`, and zero memory writes.
- Goal (15,15) walled in on all open sides → `found`=0, `path_len`=0. Every cell reachable from (0,0) reads 2'b10.
- Dead-end corridor: (0,1)..(0,5) free with (0,6) and (1,1..5) walls, (1,0) open path to goal → rat backtracks 5 cells, final path contains no row-0 cell except (0,0).
- Async reset asserted at move 10 → outputs 0 within the same cycle. A subsequent `start` re-solves correctly.
- `start` pulsed mid-solve → ignored; result identical to an unperturbed run.
